// File: rtl/sample_clk_gen_multi_if.sv
// Bundles the configuration inputs and the per-channel sample outputs of
// sample_clk_gen_multi. The master drives dividers/enables; the slave is the generator.
// Optional tick counters appear when SAMPLE_CLK_GEN_TICK_CNT_EN is defined.
interface sample_clk_gen_multi_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 32
);
    logic [NUM_CH*CNT_WIDTH-1:0] clk_divider;
    logic [NUM_CH-1:0]           ch_enable;
    logic                        sync_start;
    logic [NUM_CH-1:0]           sample_clk;
    logic [NUM_CH-1:0]           sample_tick;
    logic [NUM_CH-1:0]           ch_active;
`ifdef SAMPLE_CLK_GEN_TICK_CNT_EN
    logic [NUM_CH*32-1:0]        tick_count;

    modport master (
        output clk_divider, ch_enable, sync_start,
        input  sample_clk, sample_tick, ch_active, tick_count
    );
    modport slave (
        input  clk_divider, ch_enable, sync_start,
        output sample_clk, sample_tick, ch_active, tick_count
    );
`else
    modport master (
        output clk_divider, ch_enable, sync_start,
        input  sample_clk, sample_tick, ch_active
    );
    modport slave (
        input  clk_divider, ch_enable, sync_start,
        output sample_clk, sample_tick, ch_active
    );
`endif
endinterface

// File: rtl/sample_clk_gen_multi.sv
// Multi-channel sample clock generator. Each channel divides ACLK by its own runtime
// divider, producing a near-50% sample_clk and a one-cycle sample_tick on each rising
// edge. Divider changes apply only at period boundaries; sync_start phase-aligns channels.
// Optional macro SAMPLE_CLK_GEN_TICK_CNT_EN adds a 32-bit per-channel tick counter.
module sample_clk_gen_multi #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input logic                    ACLK,
    input logic                    ARESET,
    sample_clk_gen_multi_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StRun} ch_state_e;

    logic [NUM_CH-1:0] clk_vec;
    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] active_vec;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        ch_state_e            state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [CNT_WIDTH-1:0] d_act_q, d_act_d;
        logic [CNT_WIDTH-1:0] d_in, d_last, cnt_inc;
        logic                 clk_q, clk_d;
        logic                 tick_q, tick_d;
        logic                 d_ok;
        logic                 active;

        assign d_in    = bus.clk_divider[n*CNT_WIDTH +: CNT_WIDTH];
        assign d_ok    = d_in >= CNT_WIDTH'(2);
        // d_act >= 2 whenever in RUN, so this never underflows where it matters
        assign d_last  = d_act_q - CNT_WIDTH'(1);
        assign cnt_inc = cnt_q + CNT_WIDTH'(1);

        // State register: channel state, counter, latched divider and registered outputs
        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                d_act_q <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                d_act_q <= d_act_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        // Next-state: disable beats sync_start, sync_start beats boundary (one tick only)
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            d_act_d = d_act_q;
            clk_d   = 1'b0;
            tick_d  = 1'b0;
            if (!bus.ch_enable[n]) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else if ((bus.sync_start || state_q == StIdle || cnt_q == d_last) && d_ok) begin
                state_d = StRun;
                cnt_d   = '0;
                d_act_d = d_in;
                clk_d   = 1'b1;
                tick_d  = 1'b1;
            end else if (state_q == StRun) begin
                if (cnt_q == d_last) begin
                    // Boundary with an invalid divider: stop without a tick
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = cnt_inc < (d_act_q >> 1);
                end
            end
        end

        // Outputs: ch_active follows the registered state
        always_comb begin
            active = (state_q == StRun);
        end

        assign clk_vec[n]    = clk_q;
        assign tick_vec[n]   = tick_q;
        assign active_vec[n] = active;

`ifdef SAMPLE_CLK_GEN_TICK_CNT_EN
        logic [31:0] tick_cnt_q;

        // Tick counter: cleared on IDLE->RUN entry, counts each registered sample_tick
        always_ff @(posedge ACLK) begin
            if (ARESET) begin
                tick_cnt_q <= '0;
            end else if (state_q == StIdle && state_d == StRun) begin
                tick_cnt_q <= '0;
            end else if (tick_q) begin
                tick_cnt_q <= tick_cnt_q + 32'd1;
            end
        end

        assign bus.tick_count[n*32 +: 32] = tick_cnt_q;
`endif
    end

    assign bus.sample_clk  = clk_vec;
    assign bus.sample_tick = tick_vec;
    assign bus.ch_active   = active_vec;

endmodule

// File: tb/tb_sample_clk_gen_multi.sv
// Directed bench for sample_clk_gen_multi (NUM_CH=4, CNT_WIDTH=32).
// Define SAMPLE_CLK_GEN_TICK_CNT_EN to also exercise the tick counters.
module tb_sample_clk_gen_multi;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   c;

    sample_clk_gen_multi_if #(.NUM_CH(4), .CNT_WIDTH(32)) bus ();

    sample_clk_gen_multi #(.NUM_CH(4), .CNT_WIDTH(32)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_div(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
        bus.clk_divider = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.ch_enable  = '0;
        bus.sync_start = 1'b0;
        step(2);
        chk("reset_clk", {28'b0, bus.sample_clk}, 32'h0);
        chk("reset_active", {28'b0, bus.ch_active}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0]  exp_t, exp_c;
        logic [31:0] dv [4];

        // Reset held 3 cycles with all channels enabled at D=4
        rst            = 1'b1;
        bus.sync_start = 1'b0;
        bus.ch_enable  = 4'hF;
        set_div(4, 4, 4, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_clk", {28'b0, bus.sample_clk}, 32'h0);
            chk("rst_tick", {28'b0, bus.sample_tick}, 32'h0);
            chk("rst_active", {28'b0, bus.ch_active}, 32'h0);
        end
        rst = 1'b0;
        step();
        chk("first_tick", {28'b0, bus.sample_tick}, 32'hF);
        chk("first_clk", {28'b0, bus.sample_clk}, 32'hF);
        chk("first_active", {28'b0, bus.ch_active}, 32'hF);
        step();
        chk("d4_cnt1_clk", {28'b0, bus.sample_clk}, 32'hF);
        chk("d4_cnt1_tick", {28'b0, bus.sample_tick}, 32'h0);
        step();
        chk("d4_cnt2_clk", {28'b0, bus.sample_clk}, 32'h0);
        // Reset honoured mid-period
        rst = 1'b1;
        step();
        chk("midreset_active", {28'b0, bus.ch_active}, 32'h0);
        chk("midreset_clk", {28'b0, bus.sample_clk}, 32'h0);

        // Periods D={2,3,5,10}, 20 periods of the slowest channel
        do_reset();
        dv[0] = 2; dv[1] = 3; dv[2] = 5; dv[3] = 10;
        set_div(dv[0], dv[1], dv[2], dv[3]);
        bus.ch_enable = 4'hF;
        step();
        chk("per_entry_tick", {28'b0, bus.sample_tick}, 32'hF);
        for (int k = 1; k <= 200; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                exp_t[i] = (k % dv[i]) == 0;
                exp_c[i] = (k % dv[i]) < (dv[i] / 2);
            end
            chk("per_tick", {28'b0, bus.sample_tick}, {28'b0, exp_t});
            chk("per_clk", {28'b0, bus.sample_clk}, {28'b0, exp_c});
        end

        // Boundary reload: ch0 D=4, write D=7 at cnt=1
        do_reset();
        set_div(4, 0, 0, 0);
        bus.ch_enable = 4'b0001;
        step();
        chk("reload_entry", {31'b0, bus.sample_tick[0]}, 32'h1);
        step();
        set_div(7, 0, 0, 0);
        step();
        chk("reload_cnt2_tick", {31'b0, bus.sample_tick[0]}, 32'h0);
        step();
        chk("reload_cnt3_tick", {31'b0, bus.sample_tick[0]}, 32'h0);
        step();
        chk("reload_boundary", {31'b0, bus.sample_tick[0]}, 32'h1);
        for (int k = 1; k <= 14; k++) begin
            step();
            chk("reload_d7_tick", {31'b0, bus.sample_tick[0]}, {31'b0, (k % 7) == 0});
            chk("reload_d7_clk", {31'b0, bus.sample_clk[0]}, {31'b0, (k % 7) < 3});
        end
        chk("reload_others_idle", {28'b0, bus.ch_active}, 32'h1);

        // Disable mid-period: ch1 D=6, drop enable at cnt=2
        do_reset();
        set_div(0, 6, 0, 0);
        bus.ch_enable = 4'b0010;
        step();
        chk("dis_entry", {31'b0, bus.sample_tick[1]}, 32'h1);
        step(2);
        chk("dis_cnt2_clk", {31'b0, bus.sample_clk[1]}, 32'h1);
        bus.ch_enable = 4'b0000;
        step();
        chk("dis_clk", {31'b0, bus.sample_clk[1]}, 32'h0);
        chk("dis_active", {31'b0, bus.ch_active[1]}, 32'h0);
        chk("dis_tick", {31'b0, bus.sample_tick[1]}, 32'h0);

        // Invalid divider stops the channel at the next boundary
        bus.ch_enable = 4'b0010;
        step();
        chk("inv_entry", {31'b0, bus.sample_tick[1]}, 32'h1);
        set_div(0, 1, 0, 0);
        step(5);
        chk("inv_still_run", {31'b0, bus.ch_active[1]}, 32'h1);
        chk("inv_no_tick_yet", {31'b0, bus.sample_tick[1]}, 32'h0);
        step();
        chk("inv_stopped", {31'b0, bus.ch_active[1]}, 32'h0);
        chk("inv_no_tick", {31'b0, bus.sample_tick[1]}, 32'h0);
        chk("inv_clk_low", {31'b0, bus.sample_clk[1]}, 32'h0);
        step();
        chk("inv_stays_idle", {31'b0, bus.ch_active[1]}, 32'h0);

        // sync_start: ch0 D=8, ch1 D=12 at unrelated phases
        do_reset();
        set_div(8, 12, 0, 0);
        bus.ch_enable = 4'b0001;
        step(3);
        bus.ch_enable = 4'b0011;
        step(2);
        bus.sync_start = 1'b1;
        step();
        bus.sync_start = 1'b0;
        chk("sync_tick", {30'b0, bus.sample_tick[1:0]}, 32'h3);
        chk("sync_clk", {30'b0, bus.sample_clk[1:0]}, 32'h3);
        for (c = 1; c <= 31; c++) begin
            step();
            exp_t = {2'b00, (c % 12) == 0, (c % 8) == 0};
            chk("sync_period", {28'b0, bus.sample_tick}, {28'b0, exp_t});
        end
        // c=31: ch0 at its boundary, pulse sync_start coincident with it
        bus.sync_start = 1'b1;
        step();
        bus.sync_start = 1'b0;
        chk("sync_boundary_tick", {30'b0, bus.sample_tick[1:0]}, 32'h3);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("sync_single_tick", {30'b0, bus.sample_tick[1:0]}, {30'b0, 1'b0, k == 8});
        end

        // sync_start and disable together: disable wins
        bus.ch_enable  = 4'b0001;
        bus.sync_start = 1'b1;
        step();
        bus.sync_start = 1'b0;
        chk("sync_vs_dis_active", {30'b0, bus.ch_active[1:0]}, 32'h1);
        chk("sync_vs_dis_tick", {30'b0, bus.sample_tick[1:0]}, 32'h1);

`ifdef SAMPLE_CLK_GEN_TICK_CNT_EN
        // Tick counter: D=2 for 10 periods, then wrap via preload
        do_reset();
        set_div(2, 0, 0, 0);
        bus.ch_enable = 4'b0001;
        step();
        step(19);
        chk("tcnt_ten", bus.tick_count[31:0], 32'd10);
        force dut.g_ch[0].tick_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.g_ch[0].tick_cnt_q;
        step(2);
        chk("tcnt_max", bus.tick_count[31:0], 32'hFFFF_FFFF);
        step(2);
        chk("tcnt_wrap0", bus.tick_count[31:0], 32'h0);
        step(2);
        chk("tcnt_wrap1", bus.tick_count[31:0], 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_clk_gen_multi.md
Name: sample_clk_gen_multi

Overview:
- Parametrised multi-channel successor of the single-channel sample clock divider.
- Each channel divides ACLK by its own runtime divider.
- Each channel produces a near-50% sample clock plus a one-cycle sample strobe at each rising edge.
- Divider changes take effect only at period boundaries, so no glitches or runt pulses.
- sync_start phase-aligns all running channels.
- Sits between the AXI-Lite register bank (dividers/enables) and the AXI-Stream sample producers feeding the DMA.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_WIDTH, 32, width of each channel divider and period counter.

Ports:
- ACLK  input  1  system clock; all logic on rising edge.
- ARESET  input  1  synchronous, active-high reset.
- clk_divider  input  NUM_CH*CNT_WIDTH  per-channel divider D; channel n in bits [n*CNT_WIDTH +: CNT_WIDTH].
- ch_enable  input  NUM_CH  per-channel run enable (level).
- sync_start  input  1  one-cycle pulse; restarts all enabled channels in phase.
- sample_clk  output  NUM_CH  registered divided clock per channel.
- sample_tick  output  NUM_CH  registered one-ACLK strobe at each sample_clk rising edge.
- ch_active  output  NUM_CH  registered; 1 while channel is in RUN.

Behaviour:
- Reset: on ARESET=1 at a clock edge, every channel goes to IDLE.
  - cnt=0, d_act=0.
  - sample_clk=0, sample_tick=0, ch_active=0.
  - ARESET has priority over all other inputs and is honoured mid-period.
- Per-channel states: IDLE and RUN.
  - d_act is the active divider latched from clk_divider.
  - cnt is the period counter, 0..d_act-1.
- IDLE -> RUN: in the cycle where ch_enable[n]=1 and its divider input D>=2, the next edge sets:
  - d_act=D, cnt=0, sample_clk=1, sample_tick=1, ch_active=1.
  - Latency is one cycle from enable to the first tick.
- IDLE with D<2: the channel stays in IDLE with outputs low.
- RUN, cnt<d_act-1: cnt increments; sample_tick=0; sample_clk=(cnt+1 < d_act>>1).
  - High time = floor(D/2) cycles; low time = ceil(D/2); period exactly D cycles.
  - Example D=5: high 2, low 3. D=2: high 1, low 1. D=3: high 1, low 2.
- RUN, cnt==d_act-1 (period boundary): the divider input is re-sampled.
  - If the new D>=2: d_act=D, cnt=0, sample_clk=1, sample_tick=1.
  - If the new D<2: go to IDLE with outputs low; no tick.
- Divider writes mid-period never alter the current period.
- RUN with ch_enable[n]=0: next edge goes to IDLE.
  - sample_clk=0, sample_tick=0, ch_active=0, cnt=0.
  - The partial period is truncated; this is the only permitted runt.
- sync_start=1: every channel with ch_enable=1 and D>=2 behaves as at IDLE->RUN on the next edge, whether it was in IDLE or RUN.
  - Sets cnt=0, d_act=D, sample_clk=1, sample_tick=1.
  - All affected channels tick in the same cycle.
- Simultaneous sync_start and ch_enable deasserting: disable wins.
- Simultaneous sync_start and boundary: one tick only, not two.
- Width rules:
  - Compare cnt against d_act-1 using CNT_WIDTH-bit unsigned arithmetic.
  - d_act>=2 is guaranteed in RUN, so no underflow.
  - For d_act = 2^CNT_WIDTH-1, cnt wraps 0 only via boundary reload, never by overflow.
- Channels are fully independent except for the shared sync_start.

Optional Feature:
- Macro: SAMPLE_CLK_GEN_TICK_CNT_EN.
- Defined: adds output tick_count (NUM_CH*32), one free-running 32-bit counter per channel.
  - Increments on each sample_tick; wraps 0xFFFFFFFF -> 0.
  - Cleared by ARESET and by that channel entering RUN from IDLE.
  - Not cleared by sync_start in RUN or by boundary reloads.
  - Used by software to detect dropped DMA samples.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: ARESET=1 for 3 cycles with ch_enable=all 1s and D=4 -> all outputs 0 during reset; first tick one cycle after ARESET falls.
- Periods: NUM_CH=4, D={2,3,5,10}, enable all -> ticks every 2/3/5/10 cycles; high times 1/1/2/5 cycles; 20 periods checked.
- Boundary reload: ch0 D=4 running, write D=7 at cnt=1 -> current period stays 4 cycles; next periods 7 cycles; no extra tick.
- Disable/invalid: ch1 D=6, drop ch_enable at cnt=2 -> next edge sample_clk=0 and ch_active=0. Separately, write D=1 -> channel stops at the next boundary with no tick.
- sync_start: ch0 D=8 and ch1 D=12 free-running at unrelated phases, pulse sync_start -> both tick in the same cycle, one cycle later; subsequent periods 8 and 12. Pulse coincident with a ch0 boundary -> exactly one ch0 tick.
- Optional (SAMPLE_CLK_GEN_TICK_CNT_EN): D=2 for 10 periods -> tick_count=10. Preload counter near 0xFFFFFFFE by force -> wraps to 0, then 1.
